// File: rtl/pulse_period_meter_pkg.sv
// rtl/pulse_period_meter_pkg.sv - shared width helper for the pulse period meter
package pulse_period_meter_pkg;

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - async input synchronizer with registered rising-edge detect
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   low_q, low_d;
    logic                   rise_q, rise_d;

    // fill_q marks when the last sync stage holds a real sample rather than the
    // reset value, so an input already high at reset release never looks like a rise.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        fill_d = {fill_q[SYNC_STAGES-2:0], 1'b1};
        low_d  = fill_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & low_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            fill_q <= '0;
            low_q  <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            fill_q <= fill_d;
            low_q  <= low_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/pulse_period_meter.sv
// rtl/pulse_period_meter.sv - measures period of an async pulse stream, reports lock and loss
module pulse_period_meter
    import pulse_period_meter_pkg::*;
#(
    parameter int MAX_PERIOD  = 65535,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_TOL    = 0,
    localparam int W          = clog2_f(MAX_PERIOD + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pulse_in,
    output logic [W-1:0] period,
    output logic         period_valid,
    output logic         locked,
    output logic         timeout,
    output logic         stale
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_ARMED = 1'b1;

    localparam logic [W-1:0] CNT_LAST = W'(MAX_PERIOD - 1);
    localparam logic [W:0]   TOL      = (W + 1)'(LOCK_TOL);

    logic rise;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk     (clk),
        .reset   (reset),
        .async_in(pulse_in),
        .rise    (rise)
    );

    logic         state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] period_q, period_d;
    logic         period_valid_q, period_valid_d;
    logic         locked_q, locked_d;
    logic         timeout_q, timeout_d;
    logic         stale_q, stale_d;
    logic         have_prev_q, have_prev_d;

    logic [W:0] cnt_inc;
    logic [W:0] prev_ext;
    logic [W:0] abs_diff;

    // period_q doubles as the previous-period register for the lock compare.
    always_comb begin
        cnt_inc  = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};
        prev_ext = {1'b0, period_q};
        abs_diff = (cnt_inc >= prev_ext) ? (cnt_inc - prev_ext) : (prev_ext - cnt_inc);
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        locked_d       = locked_q;
        timeout_d      = 1'b0;
        stale_d        = stale_q;
        have_prev_d    = have_prev_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (rise) begin
                    period_d       = cnt_inc[W-1:0];
                    period_valid_d = 1'b1;
                    cnt_d          = '0;
                    stale_d        = 1'b0;
                    have_prev_d    = 1'b1;
                    locked_d       = have_prev_q && (abs_diff <= TOL);
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d   = 1'b1;
                    stale_d     = 1'b1;
                    locked_d    = 1'b0;
                    have_prev_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc[W-1:0];
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            timeout_q      <= 1'b0;
            stale_q        <= 1'b0;
            have_prev_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            timeout_q      <= timeout_d;
            stale_q        <= stale_d;
            have_prev_q    <= have_prev_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;
    assign stale        = stale_q;

endmodule
